// File: rtl/cla_multiword_adder_seq.sv
// Sequential wide adder: one 16-bit carry-lookahead slice adder reused over
// WORDS clocks, least significant slice first, with the slice carry-out
// registered and fed back as the next slice's carry-in.
module cla_multiword_adder_seq #(
    parameter int WORDS   = 4,
    parameter int SLICE_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [16*WORDS-1:0]      a,
    input  logic [16*WORDS-1:0]      b,
    input  logic                     c_in,
    output logic                     busy,
    output logic                     done,
    output logic [16*WORDS-1:0]      sum,
    output logic                     c_out,
    output logic                     overflow
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Two-level carry lookahead: 4-bit groups with group generate/propagate,
    // then a lookahead over the four groups. Returns {carry_out, sum[15:0]}.
    function automatic logic [16:0] cla16(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic        cin);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] c;
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [4:0]  gc;
        g = x & y;
        p = x ^ y;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        return {gc[4], p ^ c};
    endfunction

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_carry;
    logic [16*WORDS-1:0]   r_a;
    logic [16*WORDS-1:0]   r_b;
    logic                  r_busy;
    logic                  r_done;
    logic [16*WORDS-1:0]   r_sum;
    logic                  r_c_out;
    logic                  r_overflow;

    logic [SLICE_W-1:0]    w_a_slice;
    logic [SLICE_W-1:0]    w_b_slice;
    logic [SLICE_W:0]      w_res;

    assign w_a_slice = r_a[r_idx*SLICE_W +: SLICE_W];
    assign w_b_slice = r_b[r_idx*SLICE_W +: SLICE_W];
    assign w_res     = cla16(w_a_slice, w_b_slice, r_carry);

    // Control FSM and datapath: capture on start, one slice per clock in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sum      <= '0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_sum[r_idx*SLICE_W +: SLICE_W] <= w_res[SLICE_W-1:0];
                    r_carry <= w_res[SLICE_W];
                    if (r_idx == LAST_IDX) begin
                        r_c_out    <= w_res[SLICE_W];
                        r_overflow <= (w_a_slice[SLICE_W-1] == w_b_slice[SLICE_W-1]) &&
                                      (w_res[SLICE_W-1] != w_a_slice[SLICE_W-1]);
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_idx      <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_idx      <= r_idx + 1'b1;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign c_out    = r_c_out;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_cla_multiword_adder_seq.sv
// Directed self-checking bench for cla_multiword_adder_seq (WORDS=4).
module tb_cla_multiword_adder_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        c_out;
    logic        overflow;

    int checks;
    int failures;
    int lat;
    int bcnt;
    int dcnt;

    cla_multiword_adder_seq #(.WORDS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive operands with start for one cycle, then scramble.
    task automatic drive_start(input logic [63:0] av, input logic [63:0] bv, input logic ci);
        a = av; b = bv; c_in = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~av; b = 64'h5A5A_A5A5_3C3C_C3C3; c_in = ~ci;
    endtask

    // Starts at the first negedge after the capture edge (n=1).
    task automatic wait_done(input bit inject, output int lat_o, output int busy_o);
        lat_o = 0; busy_o = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            if (inject && n == 2) begin
                start = 1'b1; a = 64'h1; b = 64'h1; c_in = 1'b0;
            end
            if (inject && n == 3) start = 1'b0;
            if (busy) busy_o++;
            if (done) begin
                lat_o = n;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [63:0] es,
                                input logic ec, input logic eo);
        check_eq({tag, "_lat"}, 64'(lat), 64'd5);
        check_eq({tag, "_sum"}, sum, es);
        check_eq({tag, "_cout"}, {63'd0, c_out}, {63'd0, ec});
        check_eq({tag, "_ovf"}, {63'd0, overflow}, {63'd0, eo});
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; a = 64'd0; b = 64'd0; c_in = 1'b0;
        #12;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_sum", sum, 64'd0);
        check_eq("rst_flags", {62'd0, c_out, overflow}, 64'd0);
        @(negedge clk); rst = 1'b0;

        // All-ones plus one: full carry ripple through every slice.
        @(negedge clk);
        drive_start(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        check_eq("v1_busy_rise", {63'd0, busy}, 64'd1);
        wait_done(1'b0, lat, bcnt);
        check_eq("v1_busy_cycles", 64'(bcnt), 64'd4);
        check_result("v1", 64'd0, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("v1_done_pulse", {63'd0, done}, 64'd0);
        check_eq("v1_hold", sum, 64'd0);

        @(negedge clk);
        drive_start(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        wait_done(1'b0, lat, bcnt);
        check_result("v2", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

        @(negedge clk);
        drive_start(64'd40000, 64'd900, 1'b0);
        wait_done(1'b0, lat, bcnt);
        check_result("v3", 64'h0000_0000_0000_9FC4, 1'b0, 1'b0);

        @(negedge clk);
        drive_start(64'd40000, 64'd900, 1'b1);
        wait_done(1'b0, lat, bcnt);
        check_result("v3c", 64'h0000_0000_0000_9FC5, 1'b0, 1'b0);

        @(negedge clk);
        drive_start(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);
        wait_done(1'b0, lat, bcnt);
        check_result("v4", 64'h0001_0000_0001_0000, 1'b0, 1'b0);

        // Reset in the middle of RUN: outputs clear at once, no done follows.
        @(negedge clk);
        drive_start(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("mrst_sum", sum, 64'd0);
        check_eq("mrst_busy", {63'd0, busy}, 64'd0);
        check_eq("mrst_flags", {61'd0, done, c_out, overflow}, 64'd0);
        @(negedge clk); rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check_eq("mrst_no_done", 64'(dcnt), 64'd0);

        drive_start(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        wait_done(1'b0, lat, bcnt);
        check_result("v5", 64'd0, 1'b1, 1'b1);

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        drive_start(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
        wait_done(1'b1, lat, bcnt);
        check_result("v6", 64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
        drive_start(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b1);
        wait_done(1'b0, lat, bcnt);
        check_result("v7", 64'h0000_0001_0000_0001, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("v7_idle", {62'd0, busy, done}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_multiword_adder_seq.md
Name: cla_multiword_adder_seq

Overview:
Sequential wide-operand adder built around one combinational 16-bit carry-lookahead slice adder. It accepts a WORDS×16-bit operand pair on a start pulse and adds one 16-bit slice per clock, least significant slice first. The carry-out of each slice is registered and fed back as the carry-in of the next slice. It sits directly upstream of datapath consumers, reusing a single 16-bit CLA for 32/64-bit and wider additions.

Parameters:
WORDS, 4, number of 16-bit slices; operand width = 16*WORDS, minimum 1.
SLICE_W, 16, slice width; fixed at 16, not to be overridden.

Ports:
clk  input  1  single system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled only when busy=0.
a  input  16*WORDS  operand A; captured on an accepted start.
b  input  16*WORDS  operand B; captured on an accepted start.
c_in  input  1  initial carry-in to slice 0; captured on an accepted start.
busy  output  1  high while slices are being processed.
done  output  1  one-cycle pulse when sum, c_out and overflow become valid.
sum  output  16*WORDS  result register.
c_out  output  1  carry-out of the most significant slice.
overflow  output  1  two's-complement overflow of the full-width add.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, c_out=0, overflow=0; operand regs, carry reg and slice index cleared. Reset mid-RUN abandons the operation, and no done is produced.
- States:
  - IDLE: busy=0. If start=1 at edge E0: capture a, b, c_in; index=0; carry=c_in; go to RUN.
  - RUN: busy=1. Each edge:
    - slice[index] of sum <= A_slice + B_slice + carry, computed by the 16-bit CLA;
    - carry <= slice carry-out;
    - index++.
  - RUN exit: at the edge writing slice WORDS-1, also load c_out and overflow, pulse done, and go to IDLE.
- Overflow is computed on the top slice only: (a_msb == b_msb) && (sum_msb != a_msb).
- Latency:
  - busy rises after E0 and falls after E_WORDS.
  - done=1 for exactly the cycle following E_WORDS.
  - WORDS=1 gives a one-cycle operation.
- Slices not yet processed keep their previous sum value during RUN. sum is only guaranteed coherent while done=1 and afterwards.
- sum, c_out and overflow hold until the next accepted start. The slice-0 write of the next operation begins changing sum.
- start while busy=1: ignored, with no queuing. Operand inputs may change freely after the capture edge.
- start in the cycle done=1: accepted, since state is IDLE. Back-to-back operations give a throughput of one add per WORDS+1 cycles.
- Wrap-around: the sum is modulo 2^(16*WORDS), and the carry out of the top slice appears only on c_out.
- Simultaneous rst and start: rst wins.

Test Plan:
- Reset, then WORDS=4, a=0xFFFF_FFFF_FFFF_FFFF, b=1, c_in=0, start pulse -> busy high 4 cycles; done pulse; sum=0, c_out=1, overflow=0.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1, c_in=0 -> sum=0x8000_0000_0000_0000, c_out=0, overflow=1.
- a=40000 (0x9C40), b=900, upper slices 0, c_in=0 -> sum=0x0000_0000_0000_9FC4, c_out=0, overflow=0. Repeat with c_in=1 -> sum=0x9FC5.
- Cross-slice carry: a=0x0000_FFFF_0000_FFFF, b=0x0000_0001_0000_0001 -> sum=0x0001_0000_0001_0000, c_out=0.
- Start with a=b=0x8000_0000_0000_0000; assert rst during RUN cycle 2 -> all outputs 0 immediately, no done. Next start with a=b=0x8000_0000_0000_0000 -> sum=0, c_out=1, overflow=1.
- Second start pulsed during busy with different operands -> ignored and the first result is unchanged. Start in the done cycle -> accepted, new done exactly 5 cycles later.
